way_partition_advisor: RTL and testbench

WAY_PARTITION_ADVISOR -- requirements
Module: way_partition_advisor

---
 rtl/way_partition_advisor_pkg.sv | 11 +
 rtl/way_hit_counter_bank.sv | 33 +++
 rtl/way_partition_advisor.sv | 76 +++++++
 tb/tb_way_partition_advisor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/way_partition_advisor_pkg.sv
// way_partition_advisor_pkg: shared FSM encoding and width helpers for the way partition advisor
// Ports: none (types and constant functions only)
package way_partition_advisor_pkg;
  typedef enum logic [1:0] {ST_COUNT, ST_SCAN, ST_UPDATE} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cmp_w(input int cw);
    return cw + 1;
  endfunction
endpackage

// File: rtl/way_hit_counter_bank.sv
// way_hit_counter_bank: cumulative per-way hit counters with an epoch snapshot bank
// Ports: clk_in/reset_in clock and sync reset; i_valid/i_hit/i_pos access stream (one-hot
//        recency position); i_snap epoch boundary; o_snap snapshot (way i = hits at position <= i)
module way_hit_counter_bank #(
  parameter int NUM_WAY       = 16,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                                    clk_in,
  input  logic                                    reset_in,
  input  logic                                    i_valid,
  input  logic                                    i_hit,
  input  logic [NUM_WAY-1:0]                      i_pos,
  input  logic                                    i_snap,
  output logic [NUM_WAY-1:0][COUNTER_WIDTH-1:0]   o_snap
);
  logic [NUM_WAY-1:0][COUNTER_WIDTH-1:0] r_live;
  logic [NUM_WAY-1:0][COUNTER_WIDTH-1:0] w_live_nxt;
  logic [NUM_WAY-1:0]                    w_cum;
  for (genvar i = 0; i < NUM_WAY; i++) begin : g_way
    assign w_cum[i]      = |i_pos[i:0];
    assign w_live_nxt[i] = r_live[i] + COUNTER_WIDTH'(i_valid && i_hit && w_cum[i] && !(&r_live[i]));
  end
  // The epoch-ending access is folded into the snapshot; the live bank restarts empty.
  always_ff @(posedge clk_in)
    if (reset_in) begin
      r_live <= '0;
      o_snap <= '0;
    end else if (i_snap) begin
      o_snap <= w_live_nxt;
      r_live <= '0;
    end else
      r_live <= w_live_nxt;
endmodule

// File: rtl/way_partition_advisor.sv
// way_partition_advisor: per-epoch utility scan suggesting a contiguous low-way allocation mask
// Ports: clk_in/reset_in clock and sync reset; access_valid_in/hit_in/hit_pos_in access stream;
//        enable_in adaptation enable; suggested_waymask_out mask; waymask_update_out new-result pulse
module way_partition_advisor import way_partition_advisor_pkg::*; #(
  parameter int NUM_WAY       = 16,
  parameter int COUNTER_WIDTH = 32,
  parameter int EPOCH_POWER   = 20,
  parameter int GAP_SHIFT     = 4,
  parameter int MIN_WAYS      = 1
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               access_valid_in,
  input  logic               hit_in,
  input  logic [NUM_WAY-1:0] hit_pos_in,
  input  logic               enable_in,
  output logic [NUM_WAY-1:0] suggested_waymask_out,
  output logic               waymask_update_out
);
  localparam int KW = idx_w(NUM_WAY);
  localparam int XW = cmp_w(COUNTER_WIDTH);
  state_t                                r_state, w_state_nxt;
  logic [EPOCH_POWER-1:0]                r_acc;
  logic [KW-1:0]                         r_k, w_k_nxt;
  logic [KW:0]                           w_k1, w_ways;
  logic [NUM_WAY-1:0]                    w_mask_nxt;
  logic                                  w_upd_nxt, w_epoch_end, w_hit;
  logic [NUM_WAY-1:0][COUNTER_WIDTH-1:0] w_snap;
  logic [COUNTER_WIDTH-1:0]              w_max;
  way_hit_counter_bank #(.NUM_WAY(NUM_WAY), .COUNTER_WIDTH(COUNTER_WIDTH)) u_bank (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .i_valid (access_valid_in),
    .i_hit   (hit_in),
    .i_pos   (hit_pos_in),
    .i_snap  (w_epoch_end),
    .o_snap  (w_snap)
  );
  // The access counter wraps exactly at 2^EPOCH_POWER, so all-ones plus one more access ends the epoch.
  assign w_epoch_end = access_valid_in && (&r_acc);
  // Cumulative counters are monotonic in way index, so the last one is the maximum.
  assign w_max  = w_snap[NUM_WAY-1];
  assign w_hit  = XW'(w_snap[r_k]) + XW'(w_max >> GAP_SHIFT) >= XW'(w_max);
  assign w_k1   = {1'b0, r_k} + (KW+1)'(1);
  assign w_ways = (w_k1 < (KW+1)'(MIN_WAYS)) ? (KW+1)'(MIN_WAYS) : w_k1;
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = '0;
    w_mask_nxt  = suggested_waymask_out;
    w_upd_nxt   = 1'b0;
    if (r_state == ST_COUNT)
      w_state_nxt = w_epoch_end ? ST_SCAN : ST_COUNT;
    else if (r_state == ST_SCAN) begin
      w_state_nxt = w_hit ? ST_UPDATE : ST_SCAN;
      w_k_nxt     = w_hit ? r_k : r_k + KW'(1);
    end else begin
      w_state_nxt = ST_COUNT;
      w_mask_nxt  = enable_in ? ~({NUM_WAY{1'b1}} << w_ways) : '1;
      w_upd_nxt   = enable_in;
    end
  end
  always_ff @(posedge clk_in)
    if (reset_in) begin
      r_state               <= ST_COUNT;
      r_acc                 <= '0;
      r_k                   <= '0;
      suggested_waymask_out <= '1;
      waymask_update_out    <= 1'b0;
    end else begin
      r_state               <= w_state_nxt;
      r_acc                 <= w_epoch_end ? '0 : r_acc + EPOCH_POWER'(access_valid_in);
      r_k                   <= w_k_nxt;
      suggested_waymask_out <= w_mask_nxt;
      waymask_update_out    <= w_upd_nxt;
    end
endmodule

// File: tb/tb_way_partition_advisor.sv
// tb_way_partition_advisor: scoreboard bench for two advisors (MIN_WAYS 1 and 2) fed the same accesses
module tb_way_partition_advisor;
  localparam int NW = 8;
  typedef struct {
    logic [NW-1:0] mask;
    int            due;
  } exp_t;
  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          access_valid_in = 1'b0;
  logic          hit_in = 1'b0;
  logic          enable_in = 1'b1;
  logic [NW-1:0] hit_pos_in = '0;
  logic [NW-1:0] mask_a, mask_b;
  logic          upd_a, upd_b;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  exp_t          q_a[$], q_b[$];
  exp_t          ea, eb;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  way_partition_advisor #(.NUM_WAY(NW), .COUNTER_WIDTH(32), .EPOCH_POWER(6), .GAP_SHIFT(3), .MIN_WAYS(1)) u_a (
    .clk_in(clk_in), .reset_in(reset_in), .access_valid_in(access_valid_in), .hit_in(hit_in),
    .hit_pos_in(hit_pos_in), .enable_in(enable_in),
    .suggested_waymask_out(mask_a), .waymask_update_out(upd_a)
  );
  way_partition_advisor #(.NUM_WAY(NW), .COUNTER_WIDTH(32), .EPOCH_POWER(6), .GAP_SHIFT(3), .MIN_WAYS(2)) u_b (
    .clk_in(clk_in), .reset_in(reset_in), .access_valid_in(access_valid_in), .hit_in(hit_in),
    .hit_pos_in(hit_pos_in), .enable_in(enable_in),
    .suggested_waymask_out(mask_b), .waymask_update_out(upd_b)
  );
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Monitor: every update pulse must match the next queued result, mask and arrival cycle.
  always @(negedge clk_in) begin
    if (upd_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pulse_a: unexpected pulse mask %h cycle %0d", mask_a, cyc);
      end else begin
        ea = q_a.pop_front();
        check("mask_a", int'(mask_a), int'(ea.mask));
        check("due_a", cyc, ea.due);
      end
    end
    if (upd_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pulse_b: unexpected pulse mask %h cycle %0d", mask_b, cyc);
      end else begin
        eb = q_b.pop_front();
        check("mask_b", int'(mask_b), int'(eb.mask));
        check("due_b", cyc, eb.due);
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      access_valid_in = 1'b0;
      hit_in          = 1'b0;
      hit_pos_in      = '0;
    end
  endtask
  // 64 accesses: n1 hits at p1, n2 hits at p2, then misses (pos bit 0 set to test hit qualification).
  // The last access lands on edge cyc+1; the mask is visible k+2 edges later.
  task automatic epoch(input int n1, input int p1, input int n2, input int p2, input bit push,
                       input int k, input logic [NW-1:0] ma, input logic [NW-1:0] mb);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      access_valid_in = 1'b1;
      hit_in          = (i < n1 + n2);
      hit_pos_in      = (i < n1) ? NW'(1 << p1) : (i < n1 + n2) ? NW'(1 << p2) : NW'(1);
    end
    if (push) begin
      e.due  = cyc + 1 + k + 2;
      e.mask = ma;
      q_a.push_back(e);
      e.mask = mb;
      q_b.push_back(e);
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk_in);
    reset_in        = 1'b1;
    access_valid_in = 1'b0;
    hit_in          = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask
  initial begin
    pulse_reset();
    check("rst_mask_a", int'(mask_a), 'hFF);
    check("rst_mask_b", int'(mask_b), 'hFF);
    check("rst_upd_a", int'(upd_a), 0);
    check("rst_upd_b", int'(upd_b), 0);
    epoch(64, 0, 0, 0, 1, 0, 8'h01, 8'h03);
    idle(12);
    check("pos0_mask_a", int'(mask_a), 'h01);
    check("pos0_mask_b", int'(mask_b), 'h03);
    // Back-to-back epochs: the second one counts while the first is scanning.
    epoch(64, 5, 0, 0, 1, 5, 8'h3F, 8'h3F);
    epoch(32, 2, 4, 6, 1, 2, 8'h07, 8'h07);
    idle(14);
    check("gap_mask_a", int'(mask_a), 'h07);
    check("gap_mask_b", int'(mask_b), 'h07);
    epoch(0, 0, 0, 0, 1, 0, 8'h01, 8'h03);
    idle(12);
    check("miss_mask_a", int'(mask_a), 'h01);
    check("miss_mask_b", int'(mask_b), 'h03);
    epoch(64, 5, 0, 0, 0, 5, 8'h3F, 8'h3F);
    idle(3);
    pulse_reset();
    check("abort_mask_a", int'(mask_a), 'hFF);
    check("abort_mask_b", int'(mask_b), 'hFF);
    idle(12);
    check("abort_hold_a", int'(mask_a), 'hFF);
    check("abort_hold_b", int'(mask_b), 'hFF);
    epoch(64, 0, 0, 0, 1, 0, 8'h01, 8'h03);
    idle(12);
    check("recover_mask_a", int'(mask_a), 'h01);
    check("recover_mask_b", int'(mask_b), 'h03);
    enable_in = 1'b0;
    idle(5);
    check("en_hold_a", int'(mask_a), 'h01);
    check("en_hold_b", int'(mask_b), 'h03);
    epoch(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(12);
    check("dis_mask_a", int'(mask_a), 'hFF);
    check("dis_mask_b", int'(mask_b), 'hFF);
    enable_in = 1'b1;
    idle(5);
    check("left_a", q_a.size(), 0);
    check("left_b", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
